full_adder: RTL and testbench



---
 rtl/full_adder.sv | 68 ++++++
 tb/tb_full_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle of latency.

// Single-bit full-adder cell; purely combinational link in the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum_c,
    output logic c_out_c
);

    // Classic sum / majority-carry equations
    always_comb begin
        sum_c   = a ^ b ^ c_in;
        c_out_c = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule

module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);

    localparam int unsigned CHAIN_W = WIDTH + 1;

    // carry[0] is the external carry-in; carry[WIDTH] becomes c_out
    logic [CHAIN_W-1:0] carry_c;
    logic [WIDTH-1:0]   sum_c;

    assign carry_c[0] = c_in;

    // Ripple chain: one cell per operand bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a       (a[i]),
            .b       (b[i]),
            .c_in    (carry_c[i]),
            .sum_c   (sum_c[i]),
            .c_out_c (carry_c[i+1])
        );
    end

    // Output registers: capture on en, hold otherwise; valid marks a fresh capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                sum   <= sum_c;
                c_out <= carry_c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH = 1, 8 and 16.
module tb_full_adder;

    logic clk;
    logic rst_n;

    logic       a1, b1, c1, en1, s1, co1, v1;
    logic [7:0] a8, b8, s8;
    logic       c8, en8, co8, v8;
    logic [15:0] a16, b16, s16;
    logic        c16, en16, co16, v16;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected {out_valid, c_out, sum}
    logic [63:0] sb_q[$];

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .en(en1),
        .sum(s1), .c_out(co1), .out_valid(v1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8), .en(en8),
        .sum(s8), .c_out(co8), .out_valid(v8)
    );

    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c_in(c16), .en(en16),
        .sum(s16), .c_out(co16), .out_valid(v16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] obs1();
        return 64'({v1, co1, s1});
    endfunction

    function automatic logic [63:0] obs8();
        return 64'({v8, co8, s8});
    endfunction

    function automatic logic [63:0] obs16();
        return 64'({v16, co16, s16});
    endfunction

    // Expected packed word: valid bit above a (w+1)-bit arithmetic result
    function automatic logic [63:0] model(input int unsigned w, input logic [63:0] x,
                                          input logic [63:0] y, input logic c);
        logic [63:0] r;
        r = x + y + 64'(c);
        return (64'(1) << (w + 1)) | r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    // Advance to just past the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] combo;
        rst_n = 1'b0;
        a1 = 0; b1 = 0; c1 = 0; en1 = 0;
        a8 = 0; b8 = 0; c8 = 0; en8 = 0;
        a16 = 0; b16 = 0; c16 = 0; en16 = 0;

        // Reset state
        #1;
        chk("reset_w1", obs1(), 64'd0);
        chk("reset_w8", obs8(), 64'd0);
        chk("reset_w16", obs16(), 64'd0);
        cycle();
        rst_n = 1'b1;

        // WIDTH=1: all eight input combinations, one per cycle
        en1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1 = combo[2];
            b1 = combo[1];
            c1 = combo[0];
            sb_q.push_back(model(1, 64'(a1), 64'(b1), c1));
            cycle();
            pop_chk($sformatf("w1_combo%0d", i), obs1());
        end
        en1 = 1'b0;
        cycle();
        chk("w1_idle_valid", 64'(v1), 64'd0);

        // WIDTH=8: maximum case and wrap-around
        en8 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        sb_q.push_back({55'd0, 1'b1, 1'b1, 8'hFF});
        cycle();
        pop_chk("w8_max", obs8());
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        sb_q.push_back({55'd0, 1'b1, 1'b1, 8'h00});
        cycle();
        pop_chk("w8_wrap", obs8());

        // WIDTH=8: capture then hold for three disabled cycles
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        sb_q.push_back({55'd0, 1'b1, 1'b0, 8'h46});
        cycle();
        pop_chk("w8_capture", obs8());
        en8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'hA0 + i);
            b8 = 8'h77;
            c8 = 1'b1;
            cycle();
            chk($sformatf("w8_hold%0d", i), obs8(), {55'd0, 1'b0, 1'b0, 8'h46});
        end

        // WIDTH=16: random operands, free-running
        en16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            sb_q.push_back(model(16, 64'(a16), 64'(b16), c16));
            cycle();
            pop_chk($sformatf("w16_rand%0d", i), obs16());
        end

        // Leave a nonzero result in the 16-bit instance, then reset mid-cycle
        a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1;
        sb_q.push_back(model(16, 64'h1234, 64'h4321, 1'b1));
        cycle();
        pop_chk("w16_pre_reset", obs16());

        en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        en8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; c8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_w8", obs8(), 64'd0);
        chk("async_rst_w16", obs16(), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("rst_hold_w1_%0d", i), obs1(), 64'd0);
            chk($sformatf("rst_hold_w8_%0d", i), obs8(), 64'd0);
            chk($sformatf("rst_hold_w16_%0d", i), obs16(), 64'd0);
        end

        // First capture after release
        en1 = 1'b0;
        en8 = 1'b0;
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
        rst_n = 1'b1;
        sb_q.push_back({46'd0, 1'b1, 1'b1, 16'h0000});
        cycle();
        pop_chk("w16_first_capture", obs16());
        chk("w8_no_capture", obs8(), 64'd0);
        chk("w1_no_capture", obs1(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
